// File: rtl/dma_burst_sched.sv
// dma_burst_sched: round-robin scheduler that hands one shared DMA engine to
// NCH requesting channels. A go rise queues a burst, and the FSM walks the
// granted channel through ARB -> REQ (dma_req/dma_ack handshake with timeout)
// -> XFER (one word per cycle) -> DONE. All outputs are registered.
module dma_burst_sched #(
   parameter int NCH     = 4,
   parameter int LEN_W   = 9,
   parameter int MAX_LEN = 256,
   parameter int ACK_TO  = 16
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NCH-1:0]         go,
   input  logic [NCH*LEN_W-1:0]   len_i,
   output logic                   dma_req,
   input  logic                   dma_ack,
   output logic                   data_transfer,
   output logic [$clog2(NCH)-1:0] ch_sel,
   output logic [NCH-1:0]         done,
   output logic [NCH-1:0]         err,
   output logic                   busy
);

   localparam int CW   = $clog2(NCH);
   localparam int TO_W = $clog2(ACK_TO);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARB  = 3'd1,
      REQ  = 3'd2,
      XFER = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t               state_r, state_nxt_s;
   logic [NCH-1:0]       go_q_r;
   logic [NCH-1:0]       pend_r, pend_nxt_s;
   logic [LEN_W-1:0]     len_r [NCH];
   logic [LEN_W-1:0]     cnt_r;
   logic [TO_W-1:0]      to_r;
   logic [CW-1:0]        ptr_r;
   logic [CW-1:0]        ch_sel_r;
   logic [NCH-1:0]       err_pend_r;

   logic [NCH-1:0]       rise_s, active_s, rej_s, acc_s;
   logic [CW-1:0]        grant_s, idx_s;
   logic                 grant_ok_s;
   logic                 timeout_s, last_s;
   logic [NCH-1:0]       done_set_s, err_evt_s;

   // One-hot decode of a channel index.
   function automatic logic [NCH-1:0] onehot(input logic [CW-1:0] idx);
      onehot = NCH'(1'b1) << idx;
   endfunction

   // Saturate an over-long request to the largest burst the engine allows.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      if (l > LEN_W'(MAX_LEN)) begin
         clamp_len = LEN_W'(MAX_LEN);
      end else begin
         clamp_len = l;
      end
   endfunction

   assign ch_sel = ch_sel_r;

   // Classify each go rise as accepted (queued) or rejected (zero length, or channel already busy).
   always_comb begin
      rise_s   = go & ~go_q_r;
      active_s = {NCH{1'b0}};
      rej_s    = {NCH{1'b0}};
      acc_s    = {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
         if ((state_r == REQ || state_r == XFER || state_r == DONE) && (ch_sel_r == CW'(i))) begin
            active_s[i] = 1'b1;
         end else begin
            active_s[i] = 1'b0;
         end
         if (rise_s[i]) begin
            if (len_i[i*LEN_W +: LEN_W] == LEN_W'(0)) begin
               rej_s[i] = 1'b1;
            end else if (pend_r[i] || active_s[i]) begin
               rej_s[i] = 1'b1;
            end else begin
               acc_s[i] = 1'b1;
            end
         end else begin
            acc_s[i] = 1'b0;
         end
      end
   end

   // Round-robin pick: first pending channel after ptr; scanning downward lets the nearest win.
   always_comb begin
      grant_s    = ptr_r;
      grant_ok_s = 1'b0;
      idx_s      = ptr_r;
      for (int k = NCH; k >= 1; k--) begin
         idx_s = CW'((int'(ptr_r) + k) % NCH);
         if (pend_r[idx_s]) begin
            grant_s    = idx_s;
            grant_ok_s = 1'b1;
         end else begin
         end
      end
   end

   // Event decode: handshake timeout, last word, completion/error pulses and pending update.
   always_comb begin
      if (state_r == REQ && !dma_ack && to_r == TO_W'(ACK_TO - 1)) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
      if (state_r == XFER && cnt_r == LEN_W'(0)) begin
         last_s = 1'b1;
      end else begin
         last_s = 1'b0;
      end
      done_set_s = last_s ? onehot(ch_sel_r) : NCH'(0);
      err_evt_s  = rej_s | err_pend_r | (timeout_s ? onehot(ch_sel_r) : NCH'(0));
      pend_nxt_s = (pend_r & ~((state_r == ARB && grant_ok_s) ? onehot(grant_s) : NCH'(0))) | acc_s;
   end

   // Next-state logic of the burst sequencer.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (|pend_r) state_nxt_s = ARB;
            else         state_nxt_s = IDLE;
         end
         ARB: begin
            if (grant_ok_s) state_nxt_s = REQ;
            else            state_nxt_s = IDLE;
         end
         REQ: begin
            if (dma_ack)        state_nxt_s = XFER;
            else if (timeout_s) state_nxt_s = IDLE;
            else                state_nxt_s = REQ;
         end
         XFER: begin
            if (last_s) state_nxt_s = DONE;
            else        state_nxt_s = XFER;
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, go history and request queue. go history resets high so a go already
   // asserted when reset releases is not mistaken for a fresh rise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         go_q_r  <= {NCH{1'b1}};
         pend_r  <= {NCH{1'b0}};
         for (int i = 0; i < NCH; i++) len_r[i] <= LEN_W'(0);
      end else begin
         state_r <= state_nxt_s;
         go_q_r  <= go;
         pend_r  <= pend_nxt_s;
         for (int i = 0; i < NCH; i++) begin
            if (acc_s[i]) len_r[i] <= clamp_len(len_i[i*LEN_W +: LEN_W]);
            else          len_r[i] <= len_r[i];
         end
      end
   end

   // Word counter, ack timeout counter, grant latch and round-robin pointer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r    <= LEN_W'(0);
         to_r     <= TO_W'(0);
         ch_sel_r <= CW'(0);
         ptr_r    <= CW'(0);
      end else begin
         if (state_r == ARB && grant_ok_s) begin
            cnt_r    <= len_r[grant_s] - LEN_W'(1);
            ch_sel_r <= grant_s;
         end else if (state_r == XFER && cnt_r != LEN_W'(0)) begin
            cnt_r <= cnt_r - LEN_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
         if (state_r == REQ) to_r <= to_r + TO_W'(1);
         else                to_r <= TO_W'(0);
         if (state_r == DONE || timeout_s) ptr_r <= ch_sel_r;
         else                              ptr_r <= ptr_r;
      end
   end

   // Registered outputs. An error that would coincide with done on the same
   // channel is held back one cycle so the two pulses never overlap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dma_req       <= 1'b0;
         data_transfer <= 1'b0;
         busy          <= 1'b0;
         done          <= {NCH{1'b0}};
         err           <= {NCH{1'b0}};
         err_pend_r    <= {NCH{1'b0}};
      end else begin
         dma_req       <= (state_nxt_s == REQ);
         data_transfer <= (state_nxt_s == XFER);
         busy          <= (state_nxt_s != IDLE);
         done          <= done_set_s;
         err           <= err_evt_s & ~done_set_s;
         err_pend_r    <= err_evt_s & done_set_s;
      end
   end

endmodule

// File: tb/tb_dma_burst_sched.sv
// Directed, table-driven bench for dma_burst_sched plus hand-written
// sequences for round-robin order, ack timeout, duplicate request and reset.
module tb_dma_burst_sched;

   localparam int NCH    = 4;
   localparam int LEN_W  = 9;
   localparam int ACK_TO = 16;

   logic                 clk;
   logic                 reset_n;
   logic [NCH-1:0]       go;
   logic [NCH*LEN_W-1:0] len_i;
   logic                 dma_req;
   logic                 dma_ack;
   logic                 data_transfer;
   logic [1:0]           ch_sel;
   logic [NCH-1:0]       done;
   logic [NCH-1:0]       err;
   logic                 busy;

   int tests = 0;
   int fails = 0;
   int both_cnt = 0;
   int run_len = 0;
   int max_run = 0;

   typedef struct {
      int ch;
      int len;
      int ack_dly;
      int exp_xfer;
      int exp_req;
      int exp_done;
      int exp_err;
   } vec_t;

   vec_t vecs[6];

   dma_burst_sched #(.NCH(NCH), .LEN_W(LEN_W), .MAX_LEN(256), .ACK_TO(ACK_TO)) dut (
      .clk(clk), .reset_n(reset_n), .go(go), .len_i(len_i),
      .dma_req(dma_req), .dma_ack(dma_ack), .data_transfer(data_transfer),
      .ch_sel(ch_sel), .done(done), .err(err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Running invariants: req/transfer exclusivity and longest transfer run.
   always @(negedge clk) begin
      if (dma_req && data_transfer) both_cnt++;
      if (!reset_n || !data_transfer) begin
         run_len = 0;
      end else begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_len(input int ch, input int val);
      len_i[ch*LEN_W +: LEN_W] = LEN_W'(val);
   endtask

   task automatic do_reset();
      go = '0;
      dma_ack = 1'b0;
      #2 reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      tick();
   endtask

   // One isolated burst on channel ch; dma_ack given on the ack_dly-th REQ cycle.
   task automatic run_burst(input int ch, input int len, input int ack_dly,
                            output int n_x, output int n_req, output int n_done,
                            output int n_err, output int sel, output int align);
      int first_x, last_x, ack_obs, done_obs, idle_obs;
      bit fin;
      n_x = 0; n_req = 0; n_done = 0; n_err = 0; sel = -1;
      first_x = -1; last_x = -1; ack_obs = -1; done_obs = -1; idle_obs = -1;
      fin = 1'b0;
      set_len(ch, len);
      go[ch] = 1'b1;
      for (int cyc = 0; cyc < 700 && !fin; cyc++) begin
         tick();
         if (cyc == 0) go[ch] = 1'b0;
         if (dma_req) begin
            n_req++;
            if (sel < 0) sel = int'(ch_sel);
            if (n_req == ack_dly) begin
               dma_ack = 1'b1;
               ack_obs = cyc;
            end else begin
               dma_ack = 1'b0;
            end
         end else begin
            dma_ack = 1'b0;
         end
         if (data_transfer) begin
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            n_x++;
         end
         if (done[ch]) begin
            n_done++;
            done_obs = cyc;
         end
         if (err[ch]) n_err++;
         if (cyc >= 3 && !busy) begin
            fin = 1'b1;
            idle_obs = cyc;
         end
      end
      if (!fin) chk("burst_budget", 0, 1);
      align = int'(first_x == ack_obs + 1 && last_x - first_x + 1 == n_x &&
                   done_obs == last_x + 1 && idle_obs == done_obs + 1);
   endtask

   initial begin
      int n_x, n_req, n_done, n_err, sel, align;
      int ord[4];
      int xf[4];
      int n_ord, onehot_bad;
      int req2, err2, d2, x3, d3, last_req2, err2_obs;
      int x1, d1, e1, busy_cnt;
      bit dup_sent, fin;

      reset_n = 1'b0;
      go      = '0;
      len_i   = '0;
      dma_ack = 1'b0;

      // Reset state.
      tick();
      chk("rst_dma_req", int'(dma_req), 0);
      chk("rst_data_transfer", int'(data_transfer), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_ch_sel", int'(ch_sel), 0);
      tick();
      reset_n = 1'b1;
      tick();
      tick();

      //          ch  len ack xfer req done err
      vecs[0] = '{0,   3,  2,   3,  2,  1,   0};
      vecs[1] = '{1, 256,  1, 256,  1,  1,   0};
      vecs[2] = '{2, 300,  1, 256,  1,  1,   0};
      vecs[3] = '{3,   0,  1,   0,  0,  0,   1};
      vecs[4] = '{1,   1,  3,   1,  3,  1,   0};
      vecs[5] = '{0, 511,  1, 256,  1,  1,   0};

      for (int v = 0; v < 6; v++) begin
         run_burst(vecs[v].ch, vecs[v].len, vecs[v].ack_dly, n_x, n_req, n_done, n_err, sel, align);
         chk($sformatf("v%0d_xfer", v), n_x, vecs[v].exp_xfer);
         chk($sformatf("v%0d_req", v), n_req, vecs[v].exp_req);
         chk($sformatf("v%0d_done", v), n_done, vecs[v].exp_done);
         chk($sformatf("v%0d_err", v), n_err, vecs[v].exp_err);
         if (vecs[v].exp_xfer > 0) begin
            chk($sformatf("v%0d_ch_sel", v), sel, vecs[v].ch);
            chk($sformatf("v%0d_timing", v), align, 1);
         end
         tick();
      end

      // Round-robin: all four rise together after reset, ptr=0 -> 1,2,3,0.
      do_reset();
      for (int c = 0; c < NCH; c++) begin
         set_len(c, c + 1);
         xf[c] = 0;
         ord[c] = -1;
      end
      n_ord = 0;
      onehot_bad = 0;
      dma_ack = 1'b1;
      go = 4'hF;
      fin = 1'b0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         tick();
         if (cyc == 0) go = 4'h0;
         if (data_transfer) xf[ch_sel]++;
         if ($countones(done) > 1) onehot_bad++;
         for (int c = 0; c < NCH; c++) begin
            if (done[c] && n_ord < 4) begin
               ord[n_ord] = c;
               n_ord++;
            end
         end
         if (n_ord == 4 && !busy) fin = 1'b1;
      end
      dma_ack = 1'b0;
      chk("rr_budget", int'(fin), 1);
      chk("rr_order0", ord[0], 1);
      chk("rr_order1", ord[1], 2);
      chk("rr_order2", ord[2], 3);
      chk("rr_order3", ord[3], 0);
      for (int c = 0; c < NCH; c++) chk($sformatf("rr_xfer_ch%0d", c), xf[c], c + 1);
      chk("rr_done_onehot", onehot_bad, 0);

      // Ack timeout on ch2, then queued ch3 is served.
      do_reset();
      req2 = 0; err2 = 0; d2 = 0; x3 = 0; d3 = 0; last_req2 = -1; err2_obs = -2;
      set_len(2, 5);
      set_len(3, 2);
      go[2] = 1'b1;
      fin = 1'b0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         tick();
         if (cyc == 0) go[2] = 1'b0;
         if (cyc == 3) go[3] = 1'b1;
         if (cyc == 4) go[3] = 1'b0;
         if (dma_req && ch_sel == 2'd2) begin
            req2++;
            last_req2 = cyc;
         end
         if (err[2]) begin
            err2++;
            err2_obs = cyc;
         end
         if (done[2]) d2++;
         if (dma_req && ch_sel == 2'd3) dma_ack = 1'b1;
         else                           dma_ack = 1'b0;
         if (data_transfer && ch_sel == 2'd3) x3++;
         if (done[3]) d3++;
         if (d3 > 0 && !busy) fin = 1'b1;
      end
      dma_ack = 1'b0;
      chk("to_budget", int'(fin), 1);
      chk("to_req_cycles", req2, ACK_TO);
      chk("to_err2", err2, 1);
      chk("to_err2_timing", err2_obs, last_req2 + 1);
      chk("to_no_done2", d2, 0);
      chk("to_next_xfer", x3, 2);
      chk("to_next_done", d3, 1);

      // Duplicate go rise on ch1 mid-transfer.
      x1 = 0; d1 = 0; e1 = 0;
      dup_sent = 1'b0;
      set_len(1, 20);
      go[1] = 1'b1;
      fin = 1'b0;
      for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
         tick();
         go[1] = 1'b0;
         dma_ack = dma_req;
         if (data_transfer) x1++;
         if (done[1]) d1++;
         if (err[1]) e1++;
         if (x1 == 5 && !dup_sent) begin
            go[1] = 1'b1;
            dup_sent = 1'b1;
         end
         if (cyc >= 3 && !busy) fin = 1'b1;
      end
      dma_ack = 1'b0;
      chk("dup_budget", int'(fin), 1);
      chk("dup_err1", e1, 1);
      chk("dup_xfer", x1, 20);
      chk("dup_done", d1, 1);

      // Reset mid-transfer, then go held high across release is not a new rise.
      tick();
      x1 = 0;
      set_len(1, 50);
      go[1] = 1'b1;
      for (int cyc = 0; cyc < 100 && x1 < 10; cyc++) begin
         tick();
         go[1] = 1'b0;
         dma_ack = dma_req;
         if (data_transfer) x1++;
      end
      chk("rst_mid_reached", x1, 10);
      go[1] = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_xfer", int'(data_transfer), 0);
      chk("rst_mid_req", int'(dma_req), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_done", int'(done), 0);
      dma_ack = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      busy_cnt = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         tick();
         if (busy || dma_req || done != 4'h0) busy_cnt++;
      end
      chk("rst_held_go_ignored", busy_cnt, 0);
      go[1] = 1'b0;
      tick();
      run_burst(1, 50, 1, n_x, n_req, n_done, n_err, sel, align);
      chk("post_rst_xfer", n_x, 50);
      chk("post_rst_done", n_done, 1);

      chk("req_xfer_exclusive", both_cnt, 0);
      chk("max_run_le_256", int'(max_run <= 256), 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
